// File: rtl/pz_panel_pkg.sv
// Shared state type and constants for the PunchZombi dual-row panel scan controller.
package pz_panel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        BLANK = 2'd2,
        LATCH = 2'd3
    } scan_state_t;

    localparam int DEF_COLS      = 64;
    localparam int DEF_SCAN_ROWS = 16;

    // Bit positions inside the {R0,G0,B0,R1,G1,B1} colour word.
    localparam int R0 = 5;
    localparam int G0 = 4;
    localparam int B0 = 3;
    localparam int R1 = 2;
    localparam int G1 = 1;
    localparam int B1 = 0;

    function automatic int row_period(input int cols);
        return 2 * cols + 2;
    endfunction

endpackage

// File: rtl/pz_panel_scan_ctrl.sv
// Panel scan controller: shifts one row of colour data while the previous row is
// displayed, then blanks, latches and advances the row address.
module pz_panel_scan_ctrl
    import pz_panel_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int SCAN_ROWS = DEF_SCAN_ROWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] brightness,
    input  logic [5:0] rgb_in,
    output logic [5:0] col_idx,
    output logic [3:0] row_idx,
    output logic [5:0] panel_rgb,
    output logic       panel_clk,
    output logic       panel_lat,
    output logic       panel_oe_n,
    output logic [3:0] panel_addr,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [7:0] MAX_ON   = 8'(row_period(COLS) - 2);
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(SCAN_ROWS - 1);

    scan_state_t state, state_next;

    logic       phase;
    logic [7:0] on_time;
    logic [7:0] oe_cnt;
    logic       row_valid;
    logic       shift_end;
    logic       frame_wrap;

    function automatic logic [7:0] clamp_on(input logic [7:0] b);
        return (b > MAX_ON) ? MAX_ON : b;
    endfunction

    assign shift_end  = (state == SHIFT) && phase && (col_idx == LAST_COL);
    assign frame_wrap = (state == LATCH) && (row_idx == LAST_ROW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A row that has started always runs through LATCH; en is only consulted at row boundaries.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = SHIFT;
            SHIFT:   if (shift_end) state_next = BLANK;
            BLANK:   state_next = LATCH;
            LATCH:   state_next = en ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Panel pins are registered from the current state, so they trail col_idx by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= 1'b0;
            col_idx    <= '0;
            row_idx    <= '0;
            on_time    <= '0;
            oe_cnt     <= '0;
            row_valid  <= 1'b0;
            panel_rgb  <= '0;
            panel_clk  <= 1'b0;
            panel_lat  <= 1'b0;
            panel_oe_n <= 1'b1;
            panel_addr <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy       <= (state_next != IDLE);
            frame_done <= frame_wrap;
            panel_lat  <= (state == LATCH);
            panel_clk  <= (state == SHIFT) && phase;
            panel_oe_n <= !((state == SHIFT) && row_valid && (oe_cnt != 8'd0));

            if ((state == SHIFT) && !phase) begin
                panel_rgb <= rgb_in;
            end else if (state == IDLE) begin
                panel_rgb <= '0;
            end

            case (state)
                IDLE: begin
                    phase     <= 1'b0;
                    col_idx   <= '0;
                    row_valid <= 1'b0;
                    if (en) begin
                        row_idx <= '0;
                        on_time <= clamp_on(brightness);
                        oe_cnt  <= clamp_on(brightness);
                    end
                end
                SHIFT: begin
                    phase <= !phase;
                    if (oe_cnt != 8'd0) oe_cnt <= oe_cnt - 8'd1;
                    if (phase) col_idx <= (col_idx == LAST_COL) ? 6'd0 : col_idx + 6'd1;
                end
                LATCH: begin
                    panel_addr <= row_idx;
                    row_valid  <= 1'b1;
                    if (frame_wrap) begin
                        row_idx <= '0;
                        on_time <= clamp_on(brightness);
                        oe_cnt  <= clamp_on(brightness);
                    end else begin
                        row_idx <= row_idx + 4'd1;
                        oe_cnt  <= on_time;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pz_panel_scan_ctrl.sv
// Bench for pz_panel_scan_ctrl: directed vector table, corner sequences and random run against a row-timeline model.
module tb_pz_panel_scan_ctrl;
    import pz_panel_pkg::*;

    localparam int C  = 4;
    localparam int R  = 16;
    localparam int RP = 2 * C + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] brightness;
    logic [5:0] rgb_in;
    logic [5:0] col_idx;
    logic [3:0] row_idx;
    logic [5:0] panel_rgb;
    logic       panel_clk;
    logic       panel_lat;
    logic       panel_oe_n;
    logic [3:0] panel_addr;
    logic       frame_done;
    logic       busy;

    pz_panel_scan_ctrl #(.COLS(C), .SCAN_ROWS(R)) dut (
        .clk(clk), .rst(rst), .en(en), .brightness(brightness), .rgb_in(rgb_in),
        .col_idx(col_idx), .row_idx(row_idx), .panel_rgb(panel_rgb),
        .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
        .panel_addr(panel_addr), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] col;
        logic [3:0] row;
        logic [5:0] rgb;
        logic       pclk;
        logic       lat;
        logic       oe_n;
        logic [3:0] addr;
        logic       fd;
        logic       busy;
    } obs_t;

    typedef struct {
        bit         rst;
        bit         en;
        logic [7:0] bri;
        logic [5:0] rgb;
        logic [5:0] col;
        logic       pclk;
        logic       lat;
        logic       oe_n;
        logic       busy;
        logic [5:0] prgb;
        logic [3:0] addr;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Model: position within the row timeline plus frame bookkeeping.
    bit   m_active, m_shown;
    int   m_pos, m_row, m_on;
    obs_t exp_o;

    vec_t tbl[23];

    function automatic obs_t sample();
        return '{col_idx, row_idx, panel_rgb, panel_clk, panel_lat, panel_oe_n, panel_addr, frame_done, busy};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_step(input bit r, input bit e_v, input logic [7:0] bri, input logic [5:0] rgb);
        int p;
        int lim;
        lim = (int'(bri) > 2 * C) ? 2 * C : int'(bri);
        if (r) begin
            m_active = 0; m_shown = 0; m_pos = 0; m_row = 0; m_on = 0;
            exp_o = '0;
            exp_o.oe_n = 1'b1;
        end else if (!m_active) begin
            exp_o.rgb = '0; exp_o.pclk = 0; exp_o.lat = 0; exp_o.oe_n = 1; exp_o.fd = 0; exp_o.col = '0;
            if (e_v) begin
                m_active = 1; m_pos = 0; m_row = 0; m_on = lim; m_shown = 0;
                exp_o.busy = 1; exp_o.row = '0;
            end else begin
                exp_o.busy = 0;
            end
        end else begin
            p = m_pos;
            exp_o.pclk = (p < 2 * C) && (p % 2 == 1);
            if ((p < 2 * C) && (p % 2 == 0)) exp_o.rgb = rgb;
            exp_o.oe_n = !((p < 2 * C) && m_shown && (p < m_on));
            exp_o.lat  = (p == RP - 1);
            exp_o.fd   = exp_o.lat && (m_row == R - 1);
            if (exp_o.lat) exp_o.addr = 4'(m_row);
            if (p + 1 < RP) begin
                m_pos = p + 1;
                exp_o.col  = (p + 1 < 2 * C) ? 6'((p + 1) / 2) : 6'd0;
                exp_o.busy = 1;
            end else begin
                m_shown = 1;
                exp_o.col = '0;
                if (m_row == R - 1) begin
                    m_row = 0;
                    m_on  = lim;
                end else begin
                    m_row = m_row + 1;
                end
                exp_o.row = 4'(m_row);
                if (e_v) begin
                    m_pos = 0;
                    exp_o.busy = 1;
                end else begin
                    m_active = 0;
                    exp_o.busy = 0;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit e_v, input logic [7:0] bri, input logic [5:0] rgb);
        obs_t got;
        rst = r; en = e_v; brightness = bri; rgb_in = rgb;
        model_step(r, e_v, bri, rgb);
        @(posedge clk);
        #1;
        cyc++;
        got = sample();
        vectors++;
        if (got !== exp_o) begin
            miscompares++;
            $display("FAIL model: got %h, expected %h (cycle %0d)", got, exp_o, cyc);
        end
    endtask

    task automatic setv(input int i, input bit r, input bit e_v, input logic [7:0] bri, input logic [5:0] rgb,
                        input logic [5:0] col, input logic pc, input logic lt, input logic oe,
                        input logic bz, input logic [5:0] prgb, input logic [3:0] addr);
        tbl[i] = '{r, e_v, bri, rgb, col, pc, lt, oe, bz, prgb, addr};
    endtask

    initial begin
        logic [5:0] pat;
        int         low, lat_n, fd_n;
        bit         seen;
        logic [7:0] b;
        int         bri_set[3];
        int         bri_exp[3];

        pat = '0;
        pat[R0] = 1'b1; pat[B0] = 1'b1; pat[G1] = 1'b1;

        rst = 1'b1; en = 1'b0; brightness = '0; rgb_in = '0;

        // rst, en, bri, rgb, col, pclk, lat, oe_n, busy, panel_rgb, addr
        setv(0,  1, 0, 0, pat, 0, 0, 0, 1, 0, 0,   0);
        setv(1,  1, 0, 0, pat, 0, 0, 0, 1, 0, 0,   0);
        setv(2,  0, 1, 3, pat, 0, 0, 0, 1, 1, 0,   0);
        setv(3,  0, 1, 3, pat, 0, 0, 0, 1, 1, pat, 0);
        setv(4,  0, 1, 3, pat, 1, 1, 0, 1, 1, pat, 0);
        setv(5,  0, 1, 3, pat, 1, 0, 0, 1, 1, pat, 0);
        setv(6,  0, 1, 3, pat, 2, 1, 0, 1, 1, pat, 0);
        setv(7,  0, 1, 3, pat, 2, 0, 0, 1, 1, pat, 0);
        setv(8,  0, 1, 3, pat, 3, 1, 0, 1, 1, pat, 0);
        setv(9,  0, 1, 3, pat, 3, 0, 0, 1, 1, pat, 0);
        setv(10, 0, 1, 3, pat, 0, 1, 0, 1, 1, pat, 0);
        setv(11, 0, 1, 3, pat, 0, 0, 0, 1, 1, pat, 0);
        setv(12, 0, 1, 3, pat, 0, 0, 1, 1, 1, pat, 0);
        setv(13, 0, 1, 3, pat, 0, 0, 0, 0, 1, pat, 0);
        setv(14, 0, 1, 3, pat, 1, 1, 0, 0, 1, pat, 0);
        setv(15, 0, 1, 3, pat, 1, 0, 0, 0, 1, pat, 0);
        setv(16, 0, 1, 3, pat, 2, 1, 0, 1, 1, pat, 0);
        setv(17, 0, 1, 3, pat, 2, 0, 0, 1, 1, pat, 0);
        setv(18, 0, 1, 3, pat, 3, 1, 0, 1, 1, pat, 0);
        setv(19, 0, 1, 3, pat, 3, 0, 0, 1, 1, pat, 0);
        setv(20, 0, 1, 3, pat, 0, 1, 0, 1, 1, pat, 0);
        setv(21, 0, 1, 3, pat, 0, 0, 0, 1, 1, pat, 0);
        setv(22, 0, 1, 3, pat, 0, 0, 1, 1, 1, pat, 1);

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].rst, tbl[i].en, tbl[i].bri, tbl[i].rgb);
            check($sformatf("table[%0d]", i),
                  {col_idx, panel_clk, panel_lat, panel_oe_n, busy, panel_rgb, panel_addr},
                  {tbl[i].col, tbl[i].pclk, tbl[i].lat, tbl[i].oe_n, tbl[i].busy, tbl[i].prgb, tbl[i].addr});
        end

        // Reset held two cycles in the middle of a SHIFT.
        repeat (4) cycle(0, 1, 8'd3, 6'($urandom));
        cycle(1, 1, 8'd3, 6'($urandom));
        check("rst_mid_shift", {panel_oe_n, panel_lat, busy, col_idx}, {1'b1, 1'b0, 1'b0, 6'd0});
        cycle(1, 1, 8'd3, 6'($urandom));

        // On-time: first row after start stays dark, second row lit for min(brightness, 2*COLS).
        bri_set = '{0, 3, 255};
        bri_exp = '{0, 3, 8};
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 8'd0, 6'd0);
            cycle(0, 1, 8'(bri_set[k]), 6'($urandom));
            low = 0;
            for (int i = 0; i < RP; i++) begin
                cycle(0, 1, 8'(bri_set[k]), 6'($urandom));
                if (!panel_oe_n) low++;
            end
            check($sformatf("oe_first_row_b%0d", bri_set[k]), low, 0);
            low = 0;
            for (int i = 0; i < RP; i++) begin
                cycle(0, 1, 8'(bri_set[k]), 6'($urandom));
                if (!panel_oe_n) low++;
            end
            check($sformatf("oe_second_row_b%0d", bri_set[k]), low, bri_exp[k]);
        end

        // Full frame with a brightness change part-way through frame 0.
        cycle(1, 0, 8'd0, 6'd0);
        cycle(0, 1, 8'd2, 6'($urandom));
        lat_n = 0; low = 0; fd_n = 0;
        for (int i = 0; i < 400 && lat_n < 18; i++) begin
            b = (lat_n >= 5) ? 8'd5 : 8'd2;
            cycle(0, 1, b, 6'($urandom));
            if (frame_done) fd_n++;
            if (!panel_oe_n) low++;
            if (panel_lat) begin
                check("addr_seq", panel_addr, lat_n % R);
                if (lat_n == 0) check("oe_frame_first_row", low, 0);
                else if (lat_n < 16) check("oe_old_brightness", low, 2);
                else check("oe_new_brightness", low, 5);
                if (lat_n == 15) check("frame_done_once", fd_n, 1);
                lat_n++;
                low = 0;
            end
        end
        check("frame_latches", lat_n, 18);

        // en dropped during SHIFT of row 5.
        cycle(1, 0, 8'd0, 6'd0);
        cycle(0, 1, 8'd4, 6'($urandom));
        for (int i = 0; i < 300 && !(row_idx == 4'd5 && col_idx == 6'd2); i++)
            cycle(0, 1, 8'd4, 6'($urandom));
        check("reach_row5", (row_idx == 4'd5 && col_idx == 6'd2), 1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(0, 0, 8'd4, 6'($urandom));
            if (panel_lat) begin
                seen = 1;
                check("drop_addr", panel_addr, 5);
            end
        end
        check("drop_latched", seen, 1);
        repeat (3) cycle(0, 0, 8'd4, 6'($urandom));
        check("drop_idle", {busy, panel_oe_n}, 2'b01);

        // Restart from IDLE: first row dark, second row lit.
        cycle(0, 1, 8'd255, 6'($urandom));
        low = 0;
        for (int i = 0; i < RP; i++) begin
            cycle(0, 1, 8'd255, 6'($urandom));
            if (!panel_oe_n) low++;
        end
        check("restart_first_row_dark", low, 0);
        low = 0;
        for (int i = 0; i < RP; i++) begin
            cycle(0, 1, 8'd255, 6'($urandom));
            if (!panel_oe_n) low++;
        end
        check("restart_second_row", low, 8);

        // Randomised run against the model.
        for (int i = 0; i < 3000; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, b, 6'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
